bot_vel_sync: RTL and testbench
===============================

BOT_VEL_SYNC -- requirements
Module: bot_vel_sync

Interface
REQ-001 Parameter N_BOTS, default 3: number of bot channels, 2..16.
REQ-002 Parameter VEL_W, default 16: signed two's-complement velocity component width.
REQ-003 Parameter TICK_PERIOD, default 300: clock cycles between service ticks, at least 8.
REQ-004 Port clk  in  1: single clock; all logic on rising edge.
REQ-005 Port rst_n  in  1: reset, synchronous, active-low.
REQ-006 Port load_valid  in  1; load_ready  out  1: velocity-load handshake.
REQ-007 Port load_ch  in  CH_W=$clog2(N_BOTS); load_vx, load_vy  in  VEL_W: target channel and velocity.
REQ-008 Port req  in  N_BOTS: per-bot single-cycle reversal-request pulses.
REQ-009 Port mode  in  1: 0 = negate velocity, 1 = stop (zero velocity); sampled per update.
REQ-010 Port out_valid  out  1; out_ready  in  1: update-report handshake.
REQ-011 Port out_ch  out  CH_W; out_vx, out_vy  out  VEL_W: report of the updated channel.
REQ-012 Port busy  out  1: high whenever FSM is not IDLE.
REQ-013 Port overrun  out  1: one-cycle pulse when a tick arrives while busy.

Function
REQ-014 Tick counter SHALL count 0..TICK_PERIOD-1 and wrap; tick is the wrap cycle; free-running regardless of FSM state.
REQ-015 req[i]=1 SHALL set pending[i]; repeated requests before service merge into one.
REQ-016 FSM states: IDLE, SCAN, UPDATE, EMIT.
REQ-017 IDLE + tick (or held tick_hold): snapshot pending into work, clear those pending bits, clear tick_hold -> SCAN; req in the snapshot cycle stays pending for next tick.
REQ-018 IDLE + tick with pending all-zero: stay IDLE, no report.
REQ-019 SCAN: grant lowest work index strictly after last_grant, wrapping (round-robin), -> UPDATE; work all-zero -> IDLE.
REQ-020 UPDATE: mode 0 SHALL write vx,vy := -vx,-vy; mode 1 SHALL write 0,0; clear work[grant]; record last_grant; -> EMIT.
REQ-021 Negation of most-negative value SHALL saturate to most-positive value.
REQ-022 EMIT: out_valid=1 with out_ch/out_vx/out_vy holding the new values, stable until out_ready; on out_valid&&out_ready -> SCAN.
REQ-023 Latency: tick in cycle T with out_ready=1 SHALL give out_valid in T+3; each further channel every 3 cycles.
REQ-024 load_ready SHALL be 1 only in IDLE and not in a tick cycle; load_valid&&load_ready writes the channel registers next cycle.
REQ-025 load_ch >= N_BOTS SHALL be accepted and discarded.
REQ-026 Tick while not IDLE SHALL set tick_hold and pulse overrun; multiple missed ticks collapse into one hold.

Reset
REQ-027 rst_n=0 at a clock edge SHALL clear all velocities, pending, work, tick_hold, counter; last_grant := N_BOTS-1; FSM := IDLE.
REQ-028 Outputs under reset: out_valid=0, out_ch=0, out_vx=0, out_vy=0, busy=0, overrun=0, load_ready=0.
REQ-029 Reset mid-EMIT SHALL drop the report; the applied update is lost with the cleared registers.

Configuration
REQ-030 Macro BOT_VEL_SYNC_STATS_EN defined: add output upd_count  N_BOTS*16, 16-bit saturating per-channel count of completed EMIT handshakes, reset to 0.
REQ-031 Macro not defined: no upd_count port, no counter logic.

Structure
REQ-032 Shared package bot_vel_pkg SHALL hold the FSM state enum, mode encodings and the saturating-negate function.
REQ-033 Round-robin selector SHALL be one sub-module bot_rr_arb (N-bit request, last grant in; grant index and any-valid out).

Verification
REQ-034 Load ch0 (100,-50), req[0] pulse, mode 0, out_ready=1 -> at tick+3: out_ch=0, out_vx=-100, out_vy=50.
REQ-035 req=3'b111 before tick -> reports in order ch0, ch1, ch2 at tick+3, +6, +9; busy high throughout.
REQ-036 Load ch1 vx=-32768, req[1] -> out_vx=32767; mode 1 on next request -> out_vx=0, out_vy=0.
REQ-037 out_ready=0 for 500 cycles during EMIT -> outputs stable, overrun pulse at next tick, extra service pass on return to IDLE.
REQ-038 rst_n=0 during EMIT -> next cycle out_valid=0, all velocities 0; req pulse in the snapshot cycle served next tick.

Source files
------------

// File: rtl/bot_vel_pkg.sv
// Shared types and helpers for the bot velocity synchroniser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, reversal-mode encodings, saturating negate.
package bot_vel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  localparam logic MODE_NEG  = 1'b0;  // reverse: v := -v
  localparam logic MODE_STOP = 1'b1;  // halt:    v := 0

  // Two's-complement negate of a w-bit value carried sign-extended in 32 bits.
  // The most-negative w-bit value has no positive twin, so it clamps to the
  // most-positive one instead of wrapping back onto itself. Valid for w <= 32.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                 input int w);
    logic signed [31:0] mn;
    mn = -(32'sd1 <<< (w - 1));
    return (v == mn) ? (-mn - 32'sd1) : -v;
  endfunction

endpackage

// File: rtl/bot_rr_arb.sv
// Round-robin selector: lowest set request index strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller holds req/last stable while it uses the grant.
// Ports: req (N requests), last (previous grant) -> grant (index), any (req != 0).
module bot_rr_arb #(
  parameter int  N  = 3,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] grant,
  output logic          any
);

  logic [CW-1:0] idx;

  // Walk offsets 1..N from the last grant; offset N revisits 'last' itself so
  // a lone requester that was just served can still win.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = CW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/bot_vel_sync.sv
// Per-bot velocity store; on each service tick, round-robin reverses/stops requested bots and reports each.
// Latency: tick in cycle T -> first report valid in T+3, then one report every 3 cycles.
// Backpressure: a report holds (out_valid high, data stable) until out_ready; loads accepted only when idle.
// Ports: load_* (velocity write handshake), req (reversal pulses), mode (0 negate / 1 stop),
//        out_* (update report handshake), busy (FSM not idle), overrun (tick missed while busy).
// Optional: define BOT_VEL_SYNC_STATS_EN to add upd_count, 16-bit saturating report counts per bot.
module bot_vel_sync
  import bot_vel_pkg::*;
#(
  parameter int  N_BOTS      = 3,
  parameter int  VEL_W       = 16,
  parameter int  TICK_PERIOD = 300,
  localparam int CH_W        = $clog2(N_BOTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [CH_W-1:0]         load_ch,
  input  logic signed [VEL_W-1:0] load_vx,
  input  logic signed [VEL_W-1:0] load_vy,
  input  logic [N_BOTS-1:0]       req,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [VEL_W-1:0] out_vx,
  output logic signed [VEL_W-1:0] out_vy,
  output logic                    busy,
  output logic                    overrun
`ifdef BOT_VEL_SYNC_STATS_EN
  ,
  output logic [N_BOTS*16-1:0]    upd_count
`endif
);

  localparam int CNT_W = $clog2(TICK_PERIOD);

  logic [CNT_W-1:0]        cnt_q;
  logic                    tick;
  state_t                  state_q, state_d;
  logic [N_BOTS-1:0]       pend_q, work_q;
  logic                    tick_hold_q;
  logic [CH_W-1:0]         last_q, grant;
  logic                    any_work;
  logic signed [VEL_W-1:0] vx_q [N_BOTS];
  logic signed [VEL_W-1:0] vy_q [N_BOTS];
  logic [CH_W-1:0]         rep_ch_q;
  logic signed [VEL_W-1:0] rep_vx_q, rep_vy_q;
  logic signed [VEL_W-1:0] new_vx, new_vy;
  logic                    idle, snap, do_update, rep_fire, load_fire;

  assign tick      = (cnt_q == CNT_W'(TICK_PERIOD - 1));
  assign idle      = (state_q == ST_IDLE);
  assign load_fire = load_valid && load_ready;
  assign rep_fire  = out_valid && out_ready;

  // Outputs are qualified by rst_n so they read inactive while reset is held.
  assign load_ready = rst_n && idle && !tick;
  assign out_valid  = rst_n && (state_q == ST_EMIT);
  assign busy       = rst_n && !idle;
  assign overrun    = rst_n && tick && !idle;
  assign out_ch     = rep_ch_q;
  assign out_vx     = rep_vx_q;
  assign out_vy     = rep_vy_q;

  // work_q and last_q do not change between SCAN and UPDATE, so the grant
  // seen in SCAN is still the one applied in UPDATE.
  bot_rr_arb #(.N(N_BOTS)) u_arb (
    .req   (work_q),
    .last  (last_q),
    .grant (grant),
    .any   (any_work)
  );

  always_comb begin
    new_vx = '0;
    new_vy = '0;
    if (mode == MODE_NEG) begin
      new_vx = VEL_W'(sat_neg(32'(vx_q[grant]), VEL_W));
      new_vy = VEL_W'(sat_neg(32'(vy_q[grant]), VEL_W));
    end
  end

  always_comb begin
    state_d   = state_q;
    snap      = 1'b0;
    do_update = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick || tick_hold_q) begin
          snap    = 1'b1;
          state_d = (|pend_q) ? ST_SCAN : ST_IDLE;
        end
      end
      ST_SCAN:   state_d = any_work ? ST_UPDATE : ST_IDLE;
      ST_UPDATE: begin
        do_update = 1'b1;
        state_d   = ST_EMIT;
      end
      ST_EMIT:   if (rep_fire) state_d = ST_SCAN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      work_q      <= '0;
      tick_hold_q <= 1'b0;
      last_q      <= CH_W'(N_BOTS - 1);
      rep_ch_q    <= '0;
      rep_vx_q    <= '0;
      rep_vy_q    <= '0;
      for (int i = 0; i < N_BOTS; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= tick ? '0 : cnt_q + 1'b1;

      // Snapshot moves pending into work; a request landing in the snapshot
      // cycle itself survives as pending for the following tick.
      if (snap) begin
        pend_q <= req;
        work_q <= pend_q;
      end else begin
        pend_q <= pend_q | req;
        if (do_update) work_q[grant] <= 1'b0;
      end

      // Any number of ticks missed while busy collapse into one held tick.
      if (tick && !idle)  tick_hold_q <= 1'b1;
      else if (snap)      tick_hold_q <= 1'b0;

      if (do_update) begin
        vx_q[grant] <= new_vx;
        vy_q[grant] <= new_vy;
        rep_ch_q    <= grant;
        rep_vx_q    <= new_vx;
        rep_vy_q    <= new_vy;
        last_q      <= grant;
      end

      // Out-of-range channels complete the handshake but write nothing.
      if (load_fire && (int'(load_ch) < N_BOTS)) begin
        vx_q[load_ch] <= load_vx;
        vy_q[load_ch] <= load_vy;
      end
    end
  end

`ifdef BOT_VEL_SYNC_STATS_EN
  logic [15:0] upd_cnt_q [N_BOTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BOTS; i++) upd_cnt_q[i] <= '0;
    end else if (rep_fire && (upd_cnt_q[rep_ch_q] != 16'hFFFF)) begin
      upd_cnt_q[rep_ch_q] <= upd_cnt_q[rep_ch_q] + 16'd1;
    end
  end

  always_comb begin
    upd_count = '0;
    for (int i = 0; i < N_BOTS; i++) upd_count[i*16 +: 16] = upd_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_bot_vel_sync.sv
// Directed bench for bot_vel_sync: reset, negate, round-robin order, saturation, stop mode,
// backpressure with overrun, reset during a pending report.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bot_vel_sync;

  localparam int N_BOTS      = 3;
  localparam int VEL_W       = 16;
  localparam int TICK_PERIOD = 300;
  localparam int CH_W        = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    load_valid;
  logic                    load_ready;
  logic [CH_W-1:0]         load_ch;
  logic signed [VEL_W-1:0] load_vx, load_vy;
  logic [N_BOTS-1:0]       req;
  logic                    mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [VEL_W-1:0] out_vx, out_vy;
  logic                    busy;
  logic                    overrun;

  int n_cmp  = 0;
  int n_bad  = 0;
  int tb_cnt = 0;  // expected tick-counter value for the current cycle

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n)                         tb_cnt <= 0;
    else if (tb_cnt == TICK_PERIOD - 1) tb_cnt <= 0;
    else                                tb_cnt <= tb_cnt + 1;
  end

  bot_vel_sync #(
    .N_BOTS      (N_BOTS),
    .VEL_W       (VEL_W),
    .TICK_PERIOD (TICK_PERIOD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_vx    (load_vx),
    .load_vy    (load_vy),
    .req        (req),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_vx     (out_vx),
    .out_vy     (out_vy),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [CH_W-1:0] ch, input logic signed [VEL_W-1:0] vx,
                      input logic signed [VEL_W-1:0] vy);
    if (tb_cnt == TICK_PERIOD - 1) cyc();
    load_valid = 1'b1; load_ch = ch; load_vx = vx; load_vy = vy;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic pulse_req(input logic [N_BOTS-1:0] v);
    req = v;
    cyc();
    req = '0;
  endtask

  // Stops at the falling edge inside the next tick cycle; bounded by the period.
  task automatic wait_tick();
    int k;
    k = 0;
    while (tb_cnt != TICK_PERIOD - 1 && k < TICK_PERIOD + 2) begin
      cyc();
      k++;
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_ch = '0; load_vx = '0; load_vy = '0;
    req = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_reset();
    hold_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_ch !== 2'd0) begin n_bad++; $display("FAIL rst_out_ch got %0d want 0", out_ch); end
    n_cmp++; if (out_vx !== 16'sd0) begin n_bad++; $display("FAIL rst_out_vx got %0d want 0", out_vx); end
    n_cmp++; if (out_vy !== 16'sd0) begin n_bad++; $display("FAIL rst_out_vy got %0d want 0", out_vy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL rst_load_ready got %b want 0", load_ready); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_load_ready got %b want 1", load_ready); end
  endtask

  task automatic test_negate();
    load(2'd0, 16'sd100, -16'sd50);
    mode = 1'b0; out_ready = 1'b1;
    pulse_req(3'b001);
    wait_tick();
    n_cmp++; if ({load_ready, busy} !== 2'b00) begin n_bad++; $display("FAIL neg_tick_ready_busy got %b want 00", {load_ready, busy}); end
    for (int k = 1; k <= 2; k++) begin
      cyc();
      n_cmp++; if ({out_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL neg_pipe k=%0d valid_busy got %b want 01", k, {out_valid, busy}); end
    end
    cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL neg_valid got %b want 1", out_valid); end
    n_cmp++; if (out_ch !== 2'd0) begin n_bad++; $display("FAIL neg_ch got %0d want 0", out_ch); end
    n_cmp++; if (out_vx !== -16'sd100) begin n_bad++; $display("FAIL neg_vx got %0d want -100", out_vx); end
    n_cmp++; if (out_vy !== 16'sd50) begin n_bad++; $display("FAIL neg_vy got %0d want 50", out_vy); end
    repeat (2) cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL neg_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic signed [VEL_W-1:0] ex [3];
    logic signed [VEL_W-1:0] ey [3];
    logic ev, eb;
    ex[0] = -16'sd1; ey[0] = -16'sd2;
    ex[1] = -16'sd7; ey[1] = -16'sd8;
    ex[2] = 16'sd3;  ey[2] = 16'sd0;
    hold_reset();
    rst_n = 1'b1;
    cyc();
    load(2'd0, 16'sd1, 16'sd2);
    load(2'd1, 16'sd7, 16'sd8);
    load(2'd2, -16'sd3, 16'sd0);
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL rr_oob_load_ready got %b want 1", load_ready); end
    load(2'd3, 16'sd99, 16'sd99);
    pulse_req(3'b111);
    wait_tick();
    for (int k = 1; k <= 11; k++) begin
      cyc();
      ev = (k % 3 == 0) && (k <= 9);
      eb = (k <= 10);
      n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL rr_valid k=%0d got %b want %b", k, out_valid, ev); end
      n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL rr_busy k=%0d got %b want %b", k, busy, eb); end
      if (ev) begin
        n_cmp++;
        if (out_ch !== CH_W'(k / 3 - 1) || out_vx !== ex[k/3-1] || out_vy !== ey[k/3-1]) begin
          n_bad++;
          $display("FAIL rr_report k=%0d got ch%0d (%0d,%0d) want ch%0d (%0d,%0d)",
                   k, out_ch, out_vx, out_vy, k / 3 - 1, ex[k/3-1], ey[k/3-1]);
        end
      end
    end
  endtask

  task automatic test_rr_wrap();
    pulse_req(3'b010);
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_vx !== 16'sd7) begin
      n_bad++; $display("FAIL wrap_ch1 got v%b ch%0d vx%0d want v1 ch1 vx7", out_valid, out_ch, out_vx); end
    repeat (2) cyc();
    pulse_req(3'b101);
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_vx !== -16'sd3) begin
      n_bad++; $display("FAIL wrap_first got v%b ch%0d vx%0d want v1 ch2 vx-3", out_valid, out_ch, out_vx); end
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_vx !== 16'sd1) begin
      n_bad++; $display("FAIL wrap_second got v%b ch%0d vx%0d want v1 ch0 vx1", out_valid, out_ch, out_vx); end
    repeat (2) cyc();
  endtask

  task automatic test_saturate();
    load(2'd1, 16'sh8000, 16'sd32767);
    mode = 1'b0;
    pulse_req(3'b010);
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin n_bad++; $display("FAIL sat_report got v%b ch%0d want v1 ch1", out_valid, out_ch); end
    n_cmp++; if (out_vx !== 16'sd32767) begin n_bad++; $display("FAIL sat_vx got %0d want 32767", out_vx); end
    n_cmp++; if (out_vy !== -16'sd32767) begin n_bad++; $display("FAIL sat_vy got %0d want -32767", out_vy); end
    repeat (2) cyc();
    mode = 1'b1;
    pulse_req(3'b010);
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stop_valid got %b want 1", out_valid); end
    n_cmp++; if (out_vx !== 16'sd0 || out_vy !== 16'sd0) begin n_bad++; $display("FAIL stop_vel got (%0d,%0d) want (0,0)", out_vx, out_vy); end
    repeat (2) cyc();
    mode = 1'b0;
  endtask

  task automatic test_backpressure();
    int unstable, ov, ov_bad;
    unstable = 0; ov = 0; ov_bad = 0;
    load(2'd0, 16'sd10, 16'sd20);
    load(2'd1, 16'sd3, 16'sd4);
    out_ready = 1'b0;
    pulse_req(3'b001);
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_vx !== -16'sd10 || out_vy !== -16'sd20) begin
      n_bad++; $display("FAIL bp_first got v%b ch%0d (%0d,%0d) want v1 ch0 (-10,-20)", out_valid, out_ch, out_vx, out_vy); end
    for (int i = 0; i < 500; i++) begin
      req = (i == 100) ? 3'b010 : 3'b000;
      cyc();
      if (!(out_valid === 1'b1 && out_ch === 2'd0 && out_vx === -16'sd10 && out_vy === -16'sd20)) unstable++;
      if (overrun === 1'b1) ov++;
      if (overrun !== (tb_cnt == TICK_PERIOD - 1)) ov_bad++;
    end
    req = '0;
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable cycles want 0", unstable); end
    n_cmp++; if (ov != 1) begin n_bad++; $display("FAIL bp_overrun_count got %0d want 1", ov); end
    n_cmp++; if (ov_bad != 0) begin n_bad++; $display("FAIL bp_overrun_timing got %0d misplaced want 0", ov_bad); end
    out_ready = 1'b1;
    cyc();
    n_cmp++; if ({out_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL bp_scan got %b want 01", {out_valid, busy}); end
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle_busy got %b want 0", busy); end
    cyc();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_hold_pass_busy got %b want 1", busy); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_hold_update_valid got %b want 0", out_valid); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_vx !== -16'sd3 || out_vy !== -16'sd4) begin
      n_bad++; $display("FAIL bp_hold_report got v%b ch%0d (%0d,%0d) want v1 ch1 (-3,-4)", out_valid, out_ch, out_vx, out_vy); end
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid_emit();
    load(2'd2, 16'sd5, 16'sd6);
    out_ready = 1'b0;
    pulse_req(3'b100);
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_vx !== -16'sd5) begin
      n_bad++; $display("FAIL rme_emit got v%b ch%0d vx%0d want v1 ch2 vx-5", out_valid, out_ch, out_vx); end
    rst_n = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rme_drop got v%b busy%b want v0 busy0", out_valid, busy); end
    n_cmp++; if (out_vx !== 16'sd0 || out_vy !== 16'sd0) begin n_bad++; $display("FAIL rme_out_vel got (%0d,%0d) want (0,0)", out_vx, out_vy); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    pulse_req(3'b001);
    wait_tick();
    req = 3'b010;
    cyc();
    req = '0;
    repeat (2) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_vx !== 16'sd0 || out_vy !== 16'sd0) begin
      n_bad++; $display("FAIL rme_ch0 got v%b ch%0d (%0d,%0d) want v1 ch0 (0,0)", out_valid, out_ch, out_vx, out_vy); end
    repeat (3) cyc();
    n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rme_snap_deferred got %b want 00", {out_valid, busy}); end
    wait_tick();
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_vx !== 16'sd0 || out_vy !== 16'sd0) begin
      n_bad++; $display("FAIL rme_ch1 got v%b ch%0d (%0d,%0d) want v1 ch1 (0,0)", out_valid, out_ch, out_vx, out_vy); end
    repeat (2) cyc();
  endtask

  initial begin
    test_reset();
    test_negate();
    test_round_robin();
    test_rr_wrap();
    test_saturate();
    test_backpressure();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
